// File: rtl/sdram_access_sequencer.sv
// sdram_access_sequencer: sequences one SDRAM read/write access (PRECHARGE,
// ACTIVE, READ/WRITE, recovery) and owns the load strobes of the shared
// delay counter, waiting for its CountOut to reach zero between phases.
// Optional: define SDRAM_OPEN_PAGE_EN to keep the last activated row open
// and skip PRECHARGE/ACTIVE on a page hit.
//
// state  | meaning
// IDLE   | waiting for req; latches rw/addr when req is seen
// PRE    | PRECHARGE all banks, load tPRE
// PRE_W  | wait for delay counter to expire
// ACT    | ACTIVE bank/row, load tCAS
// ACT_W  | wait for delay counter to expire
// CMD    | READ or WRITE column, load tBURST
// BST_W  | burst window (data_phase high), wait for counter
// RCV    | NOP, load tWAIT
// RCV_W  | wait for counter to expire
// DONE   | one-cycle ack
module sdram_access_sequencer #(
  parameter int ROW_W  = 12,
  parameter int COL_W  = 8,
  parameter int BANK_W = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          req,
  input  logic                          rw,
  input  logic [BANK_W+ROW_W+COL_W-1:0] addr,
  input  logic [2:0]                    CountOut,
  output logic                          Load_tPRE,
  output logic                          Load_tCAS,
  output logic                          Load_tBURST,
  output logic                          Load_tWAIT,
  output logic                          CS_n,
  output logic                          RAS_n,
  output logic                          CAS_n,
  output logic                          WE_n,
  output logic [ROW_W-1:0]              sd_addr,
  output logic [BANK_W-1:0]             sd_ba,
  output logic                          data_phase,
  output logic                          dq_oe,
  output logic                          busy,
  output logic                          ack
);

  localparam int ADDR_W = BANK_W + ROW_W + COL_W;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_W, S_ACT, S_ACT_W, S_CMD, S_BST_W, S_RCV, S_RCV_W, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BANK_W-1:0]   bank_l;
  logic [ROW_W-1:0]    row_l;
  logic [COL_W-1:0]    col_l;
  logic [3:0]          cmd;
  logic                cnt_done;
  logic                page_hit;

  assign bank_l   = addr_q[ADDR_W-1 -: BANK_W];
  assign row_l    = addr_q[COL_W +: ROW_W];
  assign col_l    = addr_q[COL_W-1:0];
  assign cnt_done = (CountOut == 3'd0);

`ifdef SDRAM_OPEN_PAGE_EN
  logic              open_vld_q, open_vld_d;
  logic [BANK_W-1:0] open_bank_q, open_bank_d;
  logic [ROW_W-1:0]  open_row_q, open_row_d;

  // hit is judged against the request being latched this cycle
  assign page_hit = open_vld_q
                    && (addr[ADDR_W-1 -: BANK_W] == open_bank_q)
                    && (addr[COL_W +: ROW_W] == open_row_q);

  // open-row tracking: refreshed on every ACTIVE
  always_comb begin
    open_vld_d  = open_vld_q;
    open_bank_d = open_bank_q;
    open_row_d  = open_row_q;
    if (state_q == S_ACT) begin
      open_vld_d  = 1'b1;
      open_bank_d = bank_l;
      open_row_d  = row_l;
    end
  end

  // open-row register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      open_vld_q  <= 1'b0;
      open_bank_q <= '0;
      open_row_q  <= '0;
    end else begin
      open_vld_q  <= open_vld_d;
      open_bank_q <= open_bank_d;
      open_row_q  <= open_row_d;
    end
  end
`else
  assign page_hit = 1'b0;
`endif

  // state and latched request registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
    end
  end

  // next-state logic; CountOut is only looked at in the *_W states
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = rw;
          addr_d  = addr;
          state_d = page_hit ? S_CMD : S_PRE;
        end
      end
      S_PRE:   state_d = S_PRE_W;
      S_PRE_W: if (cnt_done) state_d = S_ACT;
      S_ACT:   state_d = S_ACT_W;
      S_ACT_W: if (cnt_done) state_d = S_CMD;
      S_CMD:   state_d = S_BST_W;
      S_BST_W: if (cnt_done) state_d = S_RCV;
      S_RCV:   state_d = S_RCV_W;
      S_RCV_W: if (cnt_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from state and latched request
  always_comb begin
    cmd         = 4'b0111;
    Load_tPRE   = 1'b0;
    Load_tCAS   = 1'b0;
    Load_tBURST = 1'b0;
    Load_tWAIT  = 1'b0;
    sd_addr     = '0;
    sd_ba       = '0;
    data_phase  = 1'b0;
    ack         = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_PRE: begin
        cmd         = 4'b0010;
        sd_addr[10] = 1'b1;
        Load_tPRE   = 1'b1;
      end
      S_ACT: begin
        cmd       = 4'b0011;
        sd_ba     = bank_l;
        sd_addr   = row_l;
        Load_tCAS = 1'b1;
      end
      S_CMD: begin
        cmd         = rw_q ? 4'b0100 : 4'b0101;
        sd_ba       = bank_l;
        sd_addr     = ROW_W'(col_l);
        Load_tBURST = 1'b1;
      end
      S_BST_W: data_phase = 1'b1;
      S_RCV:   Load_tWAIT = 1'b1;
      S_DONE:  ack = 1'b1;
      default: ;
    endcase
  end

  assign {CS_n, RAS_n, CAS_n, WE_n} = cmd;
  assign dq_oe = data_phase & rw_q;

endmodule

// File: tb/tb_sdram_access_sequencer.sv
// Bench for sdram_access_sequencer: models the delay counter, predicts every
// command/strobe/ack event from the access rules, and checks them in a
// decoupled monitor. Define SDRAM_OPEN_PAGE_EN for the open-page build.
`timescale 1ns/1ps
module tb_sdram_access_sequencer;

  localparam int ROW_W = 12, COL_W = 8, BANK_W = 2;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req = 1'b0;
  logic              rw = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [2:0]        CountOut;
  logic Load_tPRE, Load_tCAS, Load_tBURST, Load_tWAIT;
  logic CS_n, RAS_n, CAS_n, WE_n;
  logic [ROW_W-1:0]  sd_addr;
  logic [BANK_W-1:0] sd_ba;
  logic data_phase, dq_oe, busy, ack;

  always #5 clock = ~clock;

  sdram_access_sequencer #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .rw(rw), .addr(addr),
    .CountOut(CountOut),
    .Load_tPRE(Load_tPRE), .Load_tCAS(Load_tCAS), .Load_tBURST(Load_tBURST),
    .Load_tWAIT(Load_tWAIT),
    .CS_n(CS_n), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n),
    .sd_addr(sd_addr), .sd_ba(sd_ba), .data_phase(data_phase), .dq_oe(dq_oe),
    .busy(busy), .ack(ack)
  );

  // delay counter: loads give waits of 5/7/8/5 cycles, no reset
  logic [2:0] cnt_q = 3'd5;
  always @(posedge clock) begin
    if (Load_tPRE)        cnt_q <= 3'd4;
    else if (Load_tCAS)   cnt_q <= 3'd6;
    else if (Load_tBURST) cnt_q <= 3'd7;
    else if (Load_tWAIT)  cnt_q <= 3'd4;
    else if (cnt_q != 0)  cnt_q <= cnt_q - 3'd1;
  end
  assign CountOut = cnt_q;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [3:0]        cmd;
    logic [3:0]        ld;
    logic              ack;
    logic              chk_addr;
    logic [ROW_W-1:0]  a;
    logic [BANK_W-1:0] ba;
    logic              rw;
    int                busy_len;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int                free_cyc = 0;
  logic              ow_vld = 1'b0;
  logic [BANK_W-1:0] ow_bank = '0;
  logic [ROW_W-1:0]  ow_row = '0;

  task automatic push_ev(int c, logic [3:0] cm, logic [3:0] ld, logic ak, logic ca,
                         logic [ROW_W-1:0] a, logic [BANK_W-1:0] ba, logic r, int bl);
    ev_t e;
    e.cyc = c; e.cmd = cm; e.ld = ld; e.ack = ak; e.chk_addr = ca;
    e.a = a; e.ba = ba; e.rw = r; e.busy_len = bl;
    exp_q.push_back(e);
  endtask

  // request sampled at the edge ending cycle k
  task automatic model_accept(int k, logic r, logic [ADDR_W-1:0] ad);
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              hit;
    int                t;
    bank = ad[ADDR_W-1 -: BANK_W];
    row  = ad[COL_W +: ROW_W];
    col  = ad[COL_W-1:0];
    hit  = 1'b0;
`ifdef SDRAM_OPEN_PAGE_EN
    hit = ow_vld && (ow_bank == bank) && (ow_row == row);
`endif
    t = k;
    if (!hit) begin
      push_ev(t + 1, 4'b0010, 4'b1000, 1'b0, 1'b1, 12'h400, '0, r, 0);
      push_ev(t + 7, 4'b0011, 4'b0100, 1'b0, 1'b1, row, bank, r, 0);
      t = t + 14;
      ow_vld = 1'b1; ow_bank = bank; ow_row = row;
    end
    push_ev(t + 1, r ? 4'b0100 : 4'b0101, 4'b0010, 1'b0, 1'b1, ROW_W'(col), bank, r, 0);
    push_ev(t + 10, 4'b0111, 4'b0001, 1'b0, 1'b0, '0, '0, r, 0);
    push_ev(t + 16, 4'b0111, 4'b0000, 1'b1, 1'b0, '0, '0, r, hit ? 16 : 30);
    free_cyc = t + 17;
  endtask

  // drive one cycle of inputs; called just after a rising edge
  task automatic step(logic r_req, logic r_rw, logic [ADDR_W-1:0] r_ad);
    req = r_req; rw = r_rw; addr = r_ad;
    if (r_req && cyc >= free_cyc) model_accept(cyc, r_rw, r_ad);
    @(posedge clock); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), ADDR_W'($urandom));
  endtask

  function automatic logic [ADDR_W-1:0] mk(logic [BANK_W-1:0] b, logic [ROW_W-1:0] r,
                                            logic [COL_W-1:0] c);
    return {b, r, c};
  endfunction

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_cmd"}, {CS_n, RAS_n, CAS_n, WE_n}, 4'b0111);
    chk({tag, "_loads"}, {Load_tPRE, Load_tCAS, Load_tBURST, Load_tWAIT}, 4'b0000);
    chk({tag, "_busy_ack"}, {busy, ack, data_phase, dq_oe}, 4'b0000);
    chk({tag, "_addr_ba"}, {sd_addr, sd_ba}, '0);
  endtask

  // ---------------- monitor ----------------
  logic [3:0] m_cmd, m_ld;
  ev_t        m_e;
  int         dp_cnt = 0, oe_cnt = 0, bad_oe = 0, busy_cnt = 0;

  // compare every observed event against the next expected one
  always @(negedge clock) begin
    if (!reset_n) begin
      dp_cnt = 0; oe_cnt = 0; bad_oe = 0; busy_cnt = 0;
    end else begin
      m_cmd = {CS_n, RAS_n, CAS_n, WE_n};
      m_ld  = {Load_tPRE, Load_tCAS, Load_tBURST, Load_tWAIT};
      if (busy) busy_cnt++;
      if (data_phase) dp_cnt++;
      if (dq_oe) oe_cnt++;
      if (dq_oe && !data_phase) bad_oe++;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        m_e = exp_q.pop_front();
        chk("missed_event_cyc", cyc, m_e.cyc);
      end
      if (m_cmd != 4'b0111 || m_ld != 4'b0000 || ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {m_cmd, m_ld, 3'b0, ack}, {4'b0111, 4'b0000, 4'b0});
        end else begin
          m_e = exp_q.pop_front();
          chk("ev_cyc", cyc, m_e.cyc);
          chk("ev_cmd", m_cmd, m_e.cmd);
          chk("ev_load", m_ld, m_e.ld);
          chk("ev_ack", ack, m_e.ack);
          if (m_e.chk_addr) begin
            chk("ev_sd_addr", sd_addr, m_e.a);
            chk("ev_sd_ba", sd_ba, m_e.ba);
          end
          if (m_e.ack) begin
            chk("data_phase_len", dp_cnt, 8);
            chk("dq_oe_len", oe_cnt, m_e.rw ? 8 : 0);
            chk("dq_oe_outside", bad_oe, 0);
            chk("busy_len", busy_cnt, m_e.busy_len);
            dp_cnt = 0; oe_cnt = 0; bad_oe = 0; busy_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    #1;
    chk_reset_outputs("por");
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset_hold");
    reset_n = 1'b1;
    free_cyc = cyc;
    idle(10);
    chk_reset_outputs("idle_after_reset");

    // single read, single write, same-row read, different-row read
    step(1'b1, 1'b0, mk(2'd1, 12'h0A5, 8'h3C));
    idle(35);
    step(1'b1, 1'b1, mk(2'd2, 12'h123, 8'hFF));
    idle(35);
    step(1'b1, 1'b0, mk(2'd2, 12'h123, 8'h10));
    idle(35);
    step(1'b1, 1'b0, mk(2'd2, 12'h456, 8'h01));
    idle(35);

    // req held high: back-to-back accesses, everything in between ignored
    for (int i = 0; i < 95; i++)
      step(1'b1, 1'($urandom), mk(2'($urandom), 12'($urandom_range(0, 1)), 8'($urandom)));
    idle(35);

    // one access with a stray mid-access req pulse
    step(1'b1, 1'b1, mk(2'd3, 12'hABC, 8'h55));
    idle(11);
    step(1'b1, 1'b0, mk(2'd0, 12'h001, 8'h02));
    idle(30);

    // reset while in ACT_W
    step(1'b1, 1'b0, mk(2'd1, 12'h777, 8'h77));
    idle(9);
    chk("busy_before_reset", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    ow_vld = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    free_cyc = cyc;
    idle(2);
    step(1'b1, 1'b1, mk(2'd1, 12'h777, 8'h78));
    idle(35);

    // randomized traffic over a small row pool so page hits occur
    for (int i = 0; i < 400; i++) begin
      a = mk(2'($urandom_range(0, 1)), 12'($urandom_range(0, 2)), 8'($urandom));
      step(($urandom_range(0, 9) < 3), 1'($urandom), a);
    end
    idle(40);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
